// File: rtl/control_unit_fsm.sv
// Multi-cycle RV32I control unit: fetch handshake, decode, ALU/memory/writeback strobes,
// branch resolution from ALU flags and a retired-instruction counter.
module control_unit_fsm #(
  parameter int unsigned COUNTER_WIDTH = 16,
  parameter bit          TRAP_HALT     = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              instruction,
  input  logic                     instrValid,
  output logic                     instrReady,
  input  logic                     aluZero,
  input  logic                     aluNegative,
  input  logic                     aluOverflow,
  input  logic                     aluCarry,
  output logic                     loadIR,
  output logic                     writeEnable_DataMemory,
  output logic                     writeEnable_Registers,
  output logic                     muxSelect_SumVsReadData,
  output logic                     muxSelect_ImmVsDataout2,
  output logic                     SumOrSub,
  output logic                     pcWrite,
  output logic                     pcSelectBranch,
  output logic                     illegalInstr,
  output logic [COUNTER_WIDTH-1:0] instrRetired
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StBranch,
    StTrap
  } state_e;

  state_e                   state_q, state_d;
  logic [31:0]              ir_q, ir_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     trap_seen_q, trap_seen_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       is_add, is_sub, is_addi, is_lw, is_sw, is_br, is_legal, is_arith;
  logic       br_taken;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign rd     = ir_q[11:7];

  always_comb begin
    is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
    is_br   = (opcode == 7'b1100011) && (funct3 != 3'b010) && (funct3 != 3'b011);
    is_arith = is_add | is_sub | is_addi;
    is_legal = is_arith | is_lw | is_sw | is_br;
  end

  // aluCarry = 1 means rs1 >= rs2 unsigned; signed less-than is N xor V.
  always_comb begin
    br_taken = 1'b0;
    unique case (funct3)
      3'b000:  br_taken = aluZero;
      3'b001:  br_taken = ~aluZero;
      3'b100:  br_taken = aluNegative ^ aluOverflow;
      3'b101:  br_taken = ~(aluNegative ^ aluOverflow);
      3'b110:  br_taken = ~aluCarry;
      3'b111:  br_taken = aluCarry;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      StFetch: begin
        if (instrValid) begin
          ir_d    = instruction;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_br) begin
          state_d = StBranch;
        end else if (is_legal) begin
          state_d = StExecute;
        end else begin
          state_d = StTrap;
        end
      end
      StExecute:   state_d = (is_lw || is_sw) ? StMemory : StWriteback;
      StMemory:    state_d = is_lw ? StWriteback : StFetch;
      StWriteback: state_d = StFetch;
      StBranch:    state_d = StFetch;
      StTrap:      state_d = TRAP_HALT ? StTrap : StFetch;
      default:     state_d = StFetch;
    endcase
  end

  logic in_flight;
  logic in_datapath;
  logic pc_write;
  logic retire;

  always_comb begin
    in_flight   = (state_q != StFetch) && (state_q != StTrap);
    in_datapath = (state_q == StExecute) || (state_q == StMemory) || (state_q == StWriteback);
    pc_write    = (state_q == StWriteback) || ((state_q == StMemory) && is_sw) ||
                  (state_q == StBranch) || ((state_q == StTrap) && !trap_seen_q);
    retire      = pc_write && (state_q != StTrap);
    cnt_d       = cnt_q + COUNTER_WIDTH'(retire);
    // Only a halting trap needs to remember it has already issued its pcWrite.
    trap_seen_d = (state_q == StTrap) && TRAP_HALT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StFetch;
      ir_q        <= 32'h0;
      cnt_q       <= '0;
      trap_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      trap_seen_q <= trap_seen_d;
    end
  end

  // Every strobe is masked by reset_n so an asserted reset silences the datapath at once.
  always_comb begin
    instrReady              = reset_n && (state_q == StFetch);
    loadIR                  = reset_n && (state_q == StFetch) && instrValid;
    writeEnable_DataMemory  = reset_n && (state_q == StMemory) && is_sw;
    writeEnable_Registers   = reset_n && (state_q == StWriteback) && (rd != 5'd0);
    muxSelect_SumVsReadData = reset_n && in_datapath && is_arith;
    muxSelect_ImmVsDataout2 = reset_n && in_flight && (is_add || is_sub || is_br);
    SumOrSub                = reset_n && in_flight && (is_sub || is_br);
    pcWrite                 = reset_n && pc_write;
    pcSelectBranch          = reset_n && (state_q == StBranch) && br_taken;
    illegalInstr            = reset_n && (state_q == StTrap);
    instrRetired            = reset_n ? cnt_q : '0;
  end

endmodule
